data_mem_arbiter: RTL and testbench

Shares the byte-wide data memory between two 32-bit word requesters: the CPU load/store port (requester 0) and the program/debug loader (requester 1). It arbitrates between them round-robin, then turns each granted word access into four sequential byte beats on the memory port, MSB byte first. It collects read bytes into a 32-bit word and reports completion per requester. It sits between the pipeline MEM stage / loader and the data memory array.

---
 rtl/data_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a byte-wide data memory between two 32-bit word requesters.
// Optional DATA_MEM_ARB_FIXED_PRIO_EN: requester 0 always wins ties, no last-owner pointer.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              owner;
  } xact_t;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  xact_t             xact_q, xact_d;
  logic [23:0]       rbuf_q, rbuf_d;
  logic [31:0]       rdata_d;
  logic              busy_d, done0_d, done1_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic              mem_we_d, mem_re_d;
  logic              pick1;

  // Upper address bits are outside the memory and intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[31:ADDR_W], addr1[31:ADDR_W]};

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  logic last_q;

  // Last-owner pointer; reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else if (state_q == DONE) begin
      last_q <= xact_q.owner;
    end
  end

  assign pick1 = req1 & (~req0 | ~last_q);
`endif

  // Next state, operand latch, read assembly and registered-output next values.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    xact_d  = xact_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata;
    gnt0    = 1'b0;
    gnt1    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt0         = rst & ~pick1;
          gnt1         = rst & pick1;
          xact_d.we    = pick1 ? we1 : we0;
          xact_d.addr  = pick1 ? addr1[ADDR_W-1:0] : addr0[ADDR_W-1:0];
          xact_d.wdata = pick1 ? wdata1 : wdata0;
          xact_d.owner = pick1;
          state_d      = BEAT;
          beat_d       = 2'd0;
        end
      end
      BEAT: begin
        beat_d = beat_q + 2'd1;
        // mem_rdata here answers the strobe of the previous beat.
        if (!xact_q.we) begin
          case (beat_q)
            2'd1:    rbuf_d[23:16] = mem_rdata;
            2'd2:    rbuf_d[15:8]  = mem_rdata;
            2'd3:    rbuf_d[7:0]   = mem_rdata;
            default: rbuf_d        = rbuf_q;
          endcase
        end
        if (beat_q == 2'd3) begin
          state_d = xact_q.we ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        rdata_d = {rbuf_q, mem_rdata};
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    done0_d     = (state_d == DONE) & ~xact_d.owner;
    done1_d     = (state_d == DONE) & xact_d.owner;
    mem_we_d    = (state_d == BEAT) & xact_d.we;
    mem_re_d    = (state_d == BEAT) & ~xact_d.we;
    mem_addr_d  = (state_d == BEAT) ? (xact_d.addr + ADDR_W'(beat_d)) : '0;
    mem_wdata_d = 8'h00;
    if (mem_we_d) begin
      case (beat_d)
        2'd0:    mem_wdata_d = xact_d.wdata[31:24];
        2'd1:    mem_wdata_d = xact_d.wdata[23:16];
        2'd2:    mem_wdata_d = xact_d.wdata[15:8];
        default: mem_wdata_d = xact_d.wdata[7:0];
      endcase
    end
  end

  // State register and output registers, loaded from next-state values so they align with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      xact_q    <= '0;
      rbuf_q    <= 24'h0;
      rdata     <= 32'h0;
      busy      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      xact_q    <= xact_d;
      rbuf_q    <= rbuf_d;
      rdata     <= rdata_d;
      busy      <= busy_d;
      done0     <= done0_d;
      done1     <= done1_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_we    <= mem_we_d;
      mem_re    <= mem_re_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed transactions push expected gnt/beat/done
// records; a negedge monitor pops and compares them as the DUT presents each event.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
  logic        gnt0, gnt1, done0, done1, busy, mem_we, mem_re;
  logic [31:0] rdata;
  logic [7:0]  mem_addr, mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem [256];

  data_mem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read byte memory.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] off;
  } beat_t;

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
    logic [7:0]  lat;
  } done_t;

  int    exp_gnt[$];
  beat_t exp_beat[$];
  done_t exp_done[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          gnt_cyc = 0;
  logic [31:0] held_rdata = 32'h0;

  int    g_e;
  beat_t b_e;
  done_t d_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per DUT event.
  always @(negedge clk) begin
    if (gnt0 || gnt1) begin
      vectors++;
      if (exp_gnt.size() == 0) begin
        miscompares++;
        $display("FAIL gnt: got gnt1,gnt0=%b%b, none expected", gnt1, gnt0);
      end else begin
        g_e = exp_gnt.pop_front();
        if ({gnt1, gnt0} != ((g_e == 1) ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("FAIL gnt: got gnt1,gnt0=%b%b, expected requester %0d", gnt1, gnt0, g_e);
        end
      end
      gnt_cyc = cyc;
    end
    if (mem_we || mem_re) begin
      vectors++;
      if (exp_beat.size() == 0) begin
        miscompares++;
        $display("FAIL beat: got we=%b re=%b addr=%h, none expected", mem_we, mem_re, mem_addr);
      end else begin
        b_e = exp_beat.pop_front();
        if ({mem_we, mem_re, busy, mem_addr, mem_wdata, 8'(cyc - gnt_cyc)} !=
            {b_e.we, ~b_e.we, 1'b1, b_e.addr, b_e.data, b_e.off}) begin
          miscompares++;
          $display("FAIL beat: got we=%b re=%b busy=%b addr=%h data=%h off=%0d, expected we=%b addr=%h data=%h off=%0d",
                   mem_we, mem_re, busy, mem_addr, mem_wdata, cyc - gnt_cyc,
                   b_e.we, b_e.addr, b_e.data, b_e.off);
        end
      end
    end
    if (done0 || done1) begin
      vectors++;
      if (exp_done.size() == 0) begin
        miscompares++;
        $display("FAIL done: got done1,done0=%b%b, none expected", done1, done0);
      end else begin
        d_e = exp_done.pop_front();
        if ({done1, done0, rdata, 8'(cyc - gnt_cyc)} !=
            {d_e.id, ~d_e.id, d_e.rdata, d_e.lat}) begin
          miscompares++;
          $display("FAIL done: got done1,done0=%b%b rdata=%h lat=%0d, expected id=%0d rdata=%h lat=%0d",
                   done1, done0, rdata, cyc - gnt_cyc, d_e.id, d_e.rdata, d_e.lat);
        end
      end
    end
  end

  task automatic push_xact(input bit id, input bit we, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rd_exp, input int nbeats);
    beat_t b;
    done_t dn;
    exp_gnt.push_back(id ? 1 : 0);
    for (int k = 0; k < nbeats; k++) begin
      b.we   = we;
      b.addr = 8'(a + 32'(k));
      b.data = we ? 8'(d >> (8 * (3 - k))) : 8'h00;
      b.off  = 8'(k + 1);
      exp_beat.push_back(b);
    end
    if (nbeats == 4) begin
      if (!we) held_rdata = rd_exp;
      dn.id    = id;
      dn.rdata = held_rdata;
      dn.lat   = we ? 8'd5 : 8'd6;
      exp_done.push_back(dn);
    end
  endtask

  task automatic drive(input bit id, input bit r, input bit we, input logic [31:0] a,
                       input logic [31:0] d);
    if (id) begin
      req1 = r; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = we; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic wait_evt(input bit done_not_gnt, input bit id, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = done_not_gnt ? (id ? done1 : done0) : (id ? gnt1 : gnt0);
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: event not seen within 30 cycles", tag);
    end
  endtask

  task automatic run(input bit id, input bit we, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] rd_exp, input string tag);
    push_xact(id, we, a, d, rd_exp, 4);
    @(posedge clk); #1;
    drive(id, 1'b1, we, a, d);
    wait_evt(1'b1, id, tag);
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int ndone;
    // Reset state, with a request pending that must not be granted.
    req0 = 1'b1;
    #2;
    vectors++;
    if ({gnt0, gnt1, done0, done1, busy, mem_we, mem_re, mem_addr, mem_wdata, rdata} != '0) begin
      miscompares++;
      $display("FAIL reset: got gnt=%b%b done=%b%b busy=%b we=%b re=%b addr=%h wdata=%h rdata=%h, expected all 0",
               gnt1, gnt0, done1, done0, busy, mem_we, mem_re, mem_addr, mem_wdata, rdata);
    end
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    run(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, "single_write");
    run(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "read_back");
    run(1'b0, 1'b1, 32'h0000_00FE, 32'h0102_0304, 32'h0, "wrap_write");
    @(negedge clk);
    vectors++;
    if (rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rdata_hold: got %h, expected deadbeef", rdata);
    end
    run(1'b1, 1'b0, 32'h0000_00FE, 32'h0, 32'h0102_0304, "wrap_read");

    // Contention: both requesters held high across four transactions.
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    for (int n = 0; n < 4; n++) push_xact(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h0, 4);
`else
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) push_xact(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h0, 4);
      else            push_xact(1'b1, 1'b1, 32'h30, 32'h1234_5678, 32'h0, 4);
    end
`endif
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
    drive(1'b1, 1'b1, 1'b1, 32'h30, 32'h1234_5678);
    ndone = 0;
    for (int i = 0; i < 60 && ndone < 4; i++) begin
      @(negedge clk);
      if (done0 || done1) ndone++;
    end
    if (ndone < 4) begin
      vectors++;
      miscompares++;
      $display("FAIL contention: got %0d done pulses, expected 4", ndone);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);

    // Reset during the second beat of a read.
    push_xact(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_evt(1'b0, 1'b1, "reset_read_gnt");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({gnt0, gnt1, done0, done1, busy, mem_we, mem_re, mem_addr, mem_wdata, rdata} != '0) begin
      miscompares++;
      $display("FAIL mid_reset: got gnt=%b%b done=%b%b busy=%b we=%b re=%b addr=%h wdata=%h rdata=%h, expected all 0",
               gnt1, gnt0, done1, done0, busy, mem_we, mem_re, mem_addr, mem_wdata, rdata);
    end
    held_rdata = 32'h0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "read_after_reset");

    // Request dropped one cycle after its grant.
    push_xact(1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 4);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    wait_evt(1'b0, 1'b0, "req_drop_gnt");
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_evt(1'b1, 1'b0, "req_drop_done");
    repeat (5) @(posedge clk);

    @(negedge clk);
    vectors++;
    if (exp_gnt.size() + exp_beat.size() + exp_done.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d gnt, %0d beat, %0d done expectations unmet, expected 0",
               exp_gnt.size(), exp_beat.size(), exp_done.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
